hwpe_cfg_initiator: RTL

- Hardware job dispatcher that drives the HWPE configuration port as a bus initiator. It sits on the other end of the hwpe_ctrl periph slave port.
- Accepts a stream of register-write commands and buffers them in a small FIFO.
- Per job: acquires the HWPE through the ACQUIRE register, writes the buffered job registers, writes TRIGGER, then waits for the HWPE completion event.
- Lets a DMA or core offload queue launch accelerator jobs without a core issuing each individual config access.

---
 rtl/hwpe_cfg_initiator.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/hwpe_cfg_initiator.sv
// hwpe_cfg_initiator: job dispatcher that drives an HWPE config port as a bus initiator.
// Commands {last, offset, data} are queued in a FIFO and replayed as one job:
//   ACQUIRE read (with backoff retry), job register writes, TRIGGER write, wait for evt_i.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   clear_i                 sync abort (flush FIFO, FSM to IDLE, clear err_o)
//   cmd_*                   command push stream (valid/ready)
//   periph_*                initiator side of the HWPE periph port
//   evt_i                   HWPE completion pulse
//   busy_o, done_o,         status: FSM active, job-complete pulse,
//   job_id_o, err_o         id returned by ACQUIRE, sticky r_id mismatch
module hwpe_cfg_initiator #(
    parameter int unsigned         ID_WIDTH       = 8,
    parameter int unsigned         FIFO_DEPTH     = 4,
    parameter logic [31:0]         BASE_ADDR      = 32'h0,
    parameter int unsigned         BACKOFF_CYCLES = 16,
    parameter logic [ID_WIDTH-1:0] TX_ID          = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [11:0]         cmd_offset_i,
    input  logic [31:0]         cmd_data_i,
    input  logic                cmd_last_i,
    output logic                periph_req_o,
    output logic [31:0]         periph_add_o,
    output logic                periph_wen_o,
    output logic [3:0]          periph_be_o,
    output logic [31:0]         periph_data_o,
    output logic [ID_WIDTH-1:0] periph_id_o,
    input  logic                periph_gnt_i,
    input  logic [31:0]         periph_r_data_i,
    input  logic                periph_r_valid_i,
    input  logic [ID_WIDTH-1:0] periph_r_id_i,
    input  logic                evt_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [7:0]          job_id_o,
    output logic                err_o
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = $clog2(BACKOFF_CYCLES + 1);
    localparam logic [31:0] ADDR_TRIGGER = BASE_ADDR + 32'h0;
    localparam logic [31:0] ADDR_ACQUIRE = BASE_ADDR + 32'h4;
    localparam logic [BW-1:0] BO_LAST = BW'(BACKOFF_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        IDLE,
        ACQ_REQ,
        ACQ_RSP,
        BACKOFF,
        WR_REQ,
        WR_RSP,
        TRIG_REQ,
        TRIG_RSP,
        WAIT_EVT
    } state_t;

    state_t state_q, state_d;

    // FIFO entry layout: [44] last, [43:32] offset, [31:0] data
    logic [44:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          fifo_empty;
    logic          push, pop;
    logic [44:0]   head;

    logic          last_q;
    logic [7:0]    job_id_q;
    logic [BW-1:0] bo_cnt_q;
    logic          err_q;
    logic          stale_q;
    logic          in_rsp;
    logic          rsp_accept;

    logic          req;
    logic          wen;
    logic [31:0]   add;
    logic [31:0]   wdata;
    logic          done;

    logic          unused_rdata;
    assign unused_rdata = ^periph_r_data_i[30:8];

    // ---------------- command FIFO ----------------
    assign fifo_empty  = (count_q == '0);
    assign cmd_ready_o = (count_q != FULL_CNT);
    assign push        = cmd_valid_i & cmd_ready_o & ~clear_i;
    assign head        = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_last_i, cmd_offset_i, cmd_data_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    // ---------------- response tracking ----------------
    assign in_rsp = (state_q == ACQ_RSP) ||
                    (state_q == WR_RSP)  ||
                    (state_q == TRIG_RSP);

    assign rsp_accept = periph_r_valid_i & in_rsp;

    // ---------------- FSM next state / bus drive ----------------
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        wen     = 1'b0;
        add     = 32'h0;
        wdata   = 32'h0;
        pop     = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A response still owed from an aborted transfer
                // must drain before a new one may be issued.
                if (!fifo_empty && !stale_q) begin
                    state_d = ACQ_REQ;
                end
            end
            ACQ_REQ: begin
                req = 1'b1;
                wen = 1'b1;
                add = ADDR_ACQUIRE;
                if (periph_gnt_i) begin
                    state_d = ACQ_RSP;
                end
            end
            ACQ_RSP: begin
                if (periph_r_valid_i) begin
                    state_d = periph_r_data_i[31] ? BACKOFF : WR_REQ;
                end
            end
            BACKOFF: begin
                if (bo_cnt_q == BO_LAST) begin
                    state_d = ACQ_REQ;
                end
            end
            WR_REQ: begin
                // Stall with req low until the next command arrives.
                if (!fifo_empty) begin
                    req   = 1'b1;
                    add   = BASE_ADDR + {20'h0, head[43:32]};
                    wdata = head[31:0];
                    if (periph_gnt_i) begin
                        pop     = 1'b1;
                        state_d = WR_RSP;
                    end
                end
            end
            WR_RSP: begin
                if (periph_r_valid_i) begin
                    state_d = last_q ? TRIG_REQ : WR_REQ;
                end
            end
            TRIG_REQ: begin
                req = 1'b1;
                add = ADDR_TRIGGER;
                if (periph_gnt_i) begin
                    state_d = TRIG_RSP;
                end
            end
            TRIG_RSP: begin
                if (periph_r_valid_i) begin
                    state_d = WAIT_EVT;
                end
            end
            WAIT_EVT: begin
                if (evt_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear_i) begin
            state_d = IDLE;
            req     = 1'b0;
            pop     = 1'b0;
            done    = 1'b0;
        end
    end

    // ---------------- FSM and job registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q   <= 1'b0;
            job_id_q <= 8'h0;
            bo_cnt_q <= '0;
        end else begin
            if (pop) begin
                last_q <= head[44];
            end
            if (!clear_i && state_q == ACQ_RSP &&
                periph_r_valid_i && !periph_r_data_i[31]) begin
                job_id_q <= periph_r_data_i[7:0];
            end
            if (state_q == BACKOFF && !clear_i) begin
                bo_cnt_q <= bo_cnt_q + BW'(1);
            end else begin
                bo_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q   <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            if (clear_i) begin
                err_q <= 1'b0;
            end else if (rsp_accept && periph_r_id_i != TX_ID) begin
                err_q <= 1'b1;
            end
            // An abort while a response is owed leaves that response
            // in flight; remember to swallow it.
            stale_q <= (clear_i & in_rsp & ~periph_r_valid_i) |
                       (stale_q & ~periph_r_valid_i);
        end
    end

    // ---------------- outputs ----------------
    assign periph_req_o  = req;
    assign periph_add_o  = add;
    assign periph_wen_o  = wen;
    assign periph_be_o   = 4'hF;
    assign periph_data_o = wdata;
    assign periph_id_o   = TX_ID;

    assign busy_o   = (state_q != IDLE);
    assign done_o   = done;
    assign job_id_o = done ? job_id_q : 8'h0;
    assign err_o    = err_q;

endmodule
